// File: rtl/mult_sequencer.sv
// mult_sequencer: control for the execute-stage iterative multiplier.
// Launches multiplies, owns the architectural HI/LO registers, raises the
// pipeline stall while a multiply is in flight, and aborts a multiply whose
// done pulse never arrives within MAX_CYCLES busy cycles.
module mult_sequencer #(
  parameter int WIDTH      = 32,
  parameter int MAX_CYCLES = 40,
  // Counter width; 2**CNT_W must exceed MAX_CYCLES so the limit is reachable.
  parameter int CNT_W      = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mult_e,
  input  logic                 mult_sign_e,
  input  logic                 mfhi_d,
  input  logic                 mflo_d,
  input  logic                 mthi_w,
  input  logic                 mtlo_w,
  input  logic [WIDTH-1:0]     wdata_w,
  input  logic                 mult_ready,
  input  logic                 mult_done,
  input  logic [2*WIDTH-1:0]   product,
  output logic                 start_mult,
  output logic                 mult_sign,
  output logic                 stall_mult,
  output logic [WIDTH-1:0]     hi,
  output logic [WIDTH-1:0]     lo,
  output logic                 busy,
  output logic                 timeout_err
);

  // Sequencer states: IDLE waits for a multiply, BUSY waits for its result.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  // Last counter value a multiply may occupy before it is declared dead.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYCLES - 1);

  logic [0:0]       state_r;
  logic [0:0]       state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;
  logic             timeout_err_r;

  logic             idle_s;
  logic             busy_s;
  logic             start_s;
  logic             done_s;
  logic             timeout_s;
  logic             hilo_read_s;
  logic             stall_s;

  assign idle_s      = (state_r == ST_IDLE);
  assign busy_s      = (state_r == ST_BUSY);

  // The multiplier is launched only from IDLE while E holds valid operands.
  assign start_s     = idle_s & mult_e & mult_ready;

  // A done pulse outside BUSY is stale (e.g. after a reset) and is ignored.
  assign done_s      = busy_s & mult_done;

  // Give up on the multiply in its MAX_CYCLES-th busy cycle if no done came.
  assign timeout_s   = busy_s & ~mult_done & (cnt_r == CNT_LAST);

  assign hilo_read_s = mfhi_d | mflo_d;

  // Stall sources: a HI/LO read racing a multiply, a second multiply meeting
  // a busy multiplier (held in E), or a multiply waiting for a not-ready unit.
  // Deasserts the cycle after done, when HI/LO already hold the product.
  always_comb begin
    stall_s = 1'b0;
    if (hilo_read_s & (busy_s | start_s)) begin
      stall_s = 1'b1;
    end else if (mult_e & busy_s) begin
      stall_s = 1'b1;
    end else if (idle_s & mult_e & ~mult_ready) begin
      stall_s = 1'b1;
    end else begin
      stall_s = 1'b0;
    end
  end

  // Next-state selection: launch on start, leave BUSY on done or timeout.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          state_nxt_s = ST_BUSY;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (done_s | timeout_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_BUSY;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Busy-cycle counter: zero in the first BUSY cycle, +1 for each one after.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r <= '0;
    end else if (start_s) begin
      cnt_r <= '0;
    end else if (busy_s) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // HI/LO update. A completing multiply is younger than any mthi/mtlo in
  // write-back, so its product overrides both registers in a collision.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_r <= '0;
      lo_r <= '0;
    end else if (done_s) begin
      hi_r <= product[2*WIDTH-1:WIDTH];
      lo_r <= product[WIDTH-1:0];
    end else begin
      if (mthi_w) begin
        hi_r <= wdata_w;
      end else begin
        hi_r <= hi_r;
      end
      if (mtlo_w) begin
        lo_r <= wdata_w;
      end else begin
        lo_r <= lo_r;
      end
    end
  end

  // Sticky timeout flag; only reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timeout_err_r <= 1'b0;
    end else if (timeout_s) begin
      timeout_err_r <= 1'b1;
    end else begin
      timeout_err_r <= timeout_err_r;
    end
  end

  // The start pulse must be seen by the multiplier in the same cycle the
  // operands sit in E, so it and the sign are driven combinationally.
  assign start_mult  = start_s;
  assign mult_sign   = start_s & mult_sign_e;
  assign stall_mult  = stall_s;
  assign busy        = busy_s;
  assign hi          = hi_r;
  assign lo          = lo_r;
  assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_mult_sequencer.sv
// Self-checking bench for mult_sequencer with a behavioural HI/LO model.
module tb_mult_sequencer;

  logic        clk;
  logic        reset;
  logic        mult_e;
  logic        mult_sign_e;
  logic        mfhi_d;
  logic        mflo_d;
  logic        mthi_w;
  logic        mtlo_w;
  logic [31:0] wdata_w;
  logic        mult_ready;
  logic        mult_done;
  logic [63:0] product;
  logic        start_mult;
  logic        mult_sign;
  logic        stall_mult;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;

  // Reference model of architectural state.
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;
  logic        exp_tmo;

  mult_sequencer #(.WIDTH(32), .MAX_CYCLES(40), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .mult_e(mult_e), .mult_sign_e(mult_sign_e),
    .mfhi_d(mfhi_d), .mflo_d(mflo_d), .mthi_w(mthi_w), .mtlo_w(mtlo_w),
    .wdata_w(wdata_w), .mult_ready(mult_ready), .mult_done(mult_done),
    .product(product), .start_mult(start_mult), .mult_sign(mult_sign),
    .stall_mult(stall_mult), .hi(hi), .lo(lo), .busy(busy),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] mul_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
    longint sa, sb;
    longint unsigned ua, ub;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end else begin
      ua = {32'd0, a};
      ub = {32'd0, b};
      return 64'(ua * ub);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    mult_e = 1'b0; mult_sign_e = 1'b0; mfhi_d = 1'b0; mflo_d = 1'b0;
    mthi_w = 1'b0; mtlo_w = 1'b0; wdata_w = 32'd0; mult_ready = 1'b1;
    mult_done = 1'b0; product = 64'd0;
  endtask

  // One multiply of latency lat. mf_at>0 raises mflo_d from that busy cycle.
  // hold_next keeps a second multiply waiting in E and returns in the
  // first IDLE cycle, where the next do_mult call expects its start.
  task automatic do_mult(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         input int lat, input int mf_at, input logic hold_next);
    logic [63:0] p;
    logic exp_stall;
    p = mul_ref(a, b, sgn);
    mult_e = 1'b1; mult_sign_e = sgn; mult_ready = 1'b1; mflo_d = 1'b0;
    @(negedge clk);
    checks++;
    if (start_mult !== 1'b1 || mult_sign !== sgn || busy !== 1'b0 || stall_mult !== 1'b0) begin
      errors++;
      $display("FAIL mult_start got start=%b sign=%b busy=%b stall=%b exp 1 %b 0 0",
               start_mult, mult_sign, busy, stall_mult, sgn);
    end
    checks++;
    if (hi !== exp_hi || lo !== exp_lo) begin
      errors++;
      $display("FAIL hilo_before_mult got %h_%h exp %h_%h", hi, lo, exp_hi, exp_lo);
    end
    tick();
    mult_e = hold_next; mult_sign_e = 1'($urandom);
    for (int k = 1; k <= lat; k++) begin
      mflo_d = (mf_at > 0 && k >= mf_at);
      if (k == lat) begin
        mult_done = 1'b1; product = p;
      end else begin
        mult_done = 1'b0; product = {$urandom, $urandom};
      end
      exp_stall = mflo_d | hold_next;
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || start_mult !== 1'b0 || mult_sign !== 1'b0 || stall_mult !== exp_stall) begin
        errors++;
        $display("FAIL mult_busy cyc %0d got busy=%b start=%b sign=%b stall=%b exp 1 0 0 %b",
                 k, busy, start_mult, mult_sign, stall_mult, exp_stall);
      end
      tick();
    end
    mult_done = 1'b0; product = 64'd0;
    exp_hi = p[63:32]; exp_lo = p[31:0];
    if (!hold_next) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || stall_mult !== 1'b0 || start_mult !== 1'b0 ||
          hi !== exp_hi || lo !== exp_lo) begin
        errors++;
        $display("FAIL mult_after_done got busy=%b stall=%b hi=%h lo=%h exp 0 0 %h %h",
                 busy, stall_mult, hi, lo, exp_hi, exp_lo);
      end
      mflo_d = 1'b0;
      tick();
    end
  endtask

  task automatic do_mt(input logic h, input logic l, input logic [31:0] d);
    mthi_w = h; mtlo_w = l; wdata_w = d;
    tick();
    mthi_w = 1'b0; mtlo_w = 1'b0; wdata_w = 32'd0;
    if (h) exp_hi = d;
    if (l) exp_lo = d;
    @(negedge clk);
    checks++;
    if (hi !== exp_hi || lo !== exp_lo) begin
      errors++;
      $display("FAIL mthi_mtlo got %h_%h exp %h_%h", hi, lo, exp_hi, exp_lo);
    end
    tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    exp_hi = 32'd0; exp_lo = 32'd0; exp_tmo = 1'b0;
    tick(); tick();
    @(negedge clk);
    checks++;
    if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0 || timeout_err !== 1'b0 ||
        start_mult !== 1'b0 || stall_mult !== 1'b0 || mult_sign !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got hi=%h lo=%h busy=%b tmo=%b start=%b stall=%b",
               hi, lo, busy, timeout_err, start_mult, stall_mult);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_signed_mult();
    do_mult(32'hFFFF_FFFD, 32'd5, 1'b1, 33, -1, 1'b0);
    checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFF1) begin
      errors++;
      $display("FAIL signed_m3x5 got %h_%h exp ffffffff_fffffff1", hi, lo);
    end
    do_mult($urandom, $urandom, 1'b1, 7, -1, 1'b0);
    do_mult($urandom, $urandom, 1'b0, 1, -1, 1'b0);
  endtask

  task automatic test_mflo_stall();
    do_mult($urandom, $urandom, 1'b0, 12, 2, 1'b0);
  endtask

  task automatic test_back_to_back();
    // Multiply waiting for a multiplier that is not ready.
    mult_e = 1'b1; mult_sign_e = 1'b1; mult_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (stall_mult !== 1'b1 || start_mult !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL not_ready got stall=%b start=%b busy=%b exp 1 0 0",
                 stall_mult, start_mult, busy);
      end
      tick();
    end
    do_mult($urandom, $urandom, 1'b1, 6, -1, 1'b1);
    do_mult($urandom, $urandom, 1'b0, 4, -1, 1'b1);
    do_mult($urandom, $urandom, 1'b1, 3, -1, 1'b0);
  endtask

  task automatic test_mthi_collision();
    mult_e = 1'b1; mult_sign_e = 1'b0; mult_ready = 1'b1;
    tick();
    mult_e = 1'b0;
    tick(); tick();
    mult_done = 1'b1; product = 64'hAAAA_0000_0000_0001;
    mthi_w = 1'b1; wdata_w = 32'h1234_5678;
    tick();
    clear_inputs();
    exp_hi = 32'hAAAA_0000; exp_lo = 32'h0000_0001;
    @(negedge clk);
    checks++;
    if (hi !== exp_hi || lo !== exp_lo || busy !== 1'b0) begin
      errors++;
      $display("FAIL mthi_collision got %h_%h busy=%b exp aaaa0000_00000001 0", hi, lo, busy);
    end
    tick();
    do_mt(1'b0, 1'b1, 32'h0000_0055);
    do_mt(1'b1, 1'b1, $urandom);
  endtask

  task automatic test_timeout();
    mult_e = 1'b1; mult_sign_e = 1'b1; mult_ready = 1'b1;
    tick();
    mult_e = 1'b0; mfhi_d = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || stall_mult !== 1'b1 || timeout_err !== 1'b0) begin
        errors++;
        $display("FAIL timeout_busy cyc %0d got busy=%b stall=%b tmo=%b exp 1 1 0",
                 k, busy, stall_mult, timeout_err);
      end
      tick();
    end
    exp_tmo = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || stall_mult !== 1'b0 || timeout_err !== exp_tmo ||
        hi !== exp_hi || lo !== exp_lo) begin
      errors++;
      $display("FAIL timeout_end got busy=%b stall=%b tmo=%b hi=%h lo=%h exp 0 0 1 %h %h",
               busy, stall_mult, timeout_err, hi, lo, exp_hi, exp_lo);
    end
    mfhi_d = 1'b0;
    tick();
    do_mult($urandom, $urandom, 1'b0, 5, -1, 1'b0);
    checks++;
    if (timeout_err !== exp_tmo) begin
      errors++;
      $display("FAIL timeout_sticky got %b exp %b", timeout_err, exp_tmo);
    end
  endtask

  task automatic test_reset_mid();
    mult_e = 1'b1; mult_sign_e = 1'b0; mult_ready = 1'b1;
    tick();
    mult_e = 1'b0;
    for (int k = 1; k < 10; k++) tick();
    @(negedge clk);
    reset = 1'b1;
    exp_hi = 32'd0; exp_lo = 32'd0; exp_tmo = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || hi !== exp_hi || lo !== exp_lo || timeout_err !== exp_tmo) begin
      errors++;
      $display("FAIL reset_mid got busy=%b hi=%h lo=%h tmo=%b exp 0 0 0 0",
               busy, hi, lo, timeout_err);
    end
    #1;
    reset = 1'b0;
    tick();
    mult_done = 1'b1; product = {$urandom, $urandom} | 64'h1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || start_mult !== 1'b0) begin
      errors++;
      $display("FAIL stray_done_state got busy=%b start=%b exp 0 0", busy, start_mult);
    end
    tick();
    mult_done = 1'b0;
    @(negedge clk);
    checks++;
    if (hi !== exp_hi || lo !== exp_lo) begin
      errors++;
      $display("FAIL stray_done_hilo got %h_%h exp %h_%h", hi, lo, exp_hi, exp_lo);
    end
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      case ($urandom_range(0, 3))
        0: do_mult($urandom, $urandom, 1'($urandom), int'($urandom_range(1, 39)), -1, 1'b0);
        1: do_mt(1'b1, 1'b0, $urandom);
        2: do_mt(1'b0, 1'b1, $urandom);
        default: do_mt(1'b1, 1'b1, $urandom);
      endcase
    end
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_signed_mult();
    test_mflo_stall();
    test_back_to_back();
    test_mthi_collision();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_sequencer.md
Name: mult_sequencer

Overview:
- Controls the iterative multiplier in the execute stage.
- Issues its start pulse for multiply instructions in E and owns the architectural HI/LO registers.
- Generates the pipeline stall needed when mfhi/mflo, or a second multiply, meets an in-flight multiply.
- Sits between the controller, the hazard unit and the multiplier. The hazard unit ORs stall_mult into stall_f/stall_d/flush_e.

Parameters:
- WIDTH, 32, operand width; HI/LO are WIDTH bits each and product is 2*WIDTH bits.
- MAX_CYCLES, 40, busy-cycle limit before a multiply is aborted with timeout_err.
- CNT_W, 6, width of the busy-cycle counter; must satisfy 2^CNT_W > MAX_CYCLES.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- mult_e  in  1  multiply instruction valid in execute stage (already qualified by flush_e)
- mult_sign_e  in  1  1 = mult (signed), 0 = multu
- mfhi_d  in  1  mfhi instruction in decode
- mflo_d  in  1  mflo instruction in decode
- mthi_w  in  1  mthi retiring in write-back
- mtlo_w  in  1  mtlo retiring in write-back
- wdata_w  in  WIDTH  source operand for mthi/mtlo
- mult_ready  in  1  multiplier idle and able to accept start
- mult_done  in  1  multiplier result valid, single-cycle pulse
- product  in  2*WIDTH  multiplier result
- start_mult  out  1  start pulse to multiplier
- mult_sign  out  1  signedness to multiplier
- stall_mult  out  1  stall request to hazard unit
- hi  out  WIDTH  architectural HI
- lo  out  WIDTH  architectural LO
- busy  out  1  multiply in flight
- timeout_err  out  1  sticky; multiply exceeded MAX_CYCLES

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high; the ports are named clk and reset.
- Reset values: state=IDLE, hi=0, lo=0, busy=0, timeout_err=0, counter=0.
  - start_mult and stall_mult are 0 unless mult_e/mfhi_d/mflo_d are asserted while in IDLE.
  - Reset asserted mid-multiply returns to IDLE immediately. A later mult_done pulse is ignored in IDLE.
- States: IDLE, BUSY.
  - IDLE -> BUSY on mult_e & mult_ready.
  - BUSY -> IDLE on mult_done.
  - BUSY -> IDLE on counter == MAX_CYCLES-1 without mult_done (timeout).
- start_mult: combinational, equal to (state==IDLE) & mult_e & mult_ready.
  - Asserted for exactly one cycle, while operands are valid in E.
  - mult_sign = mult_sign_e in that cycle and is 0 otherwise.
- mult_e in IDLE with mult_ready=0: stall_mult=1 and no start, until mult_ready=1.
- busy = (state==BUSY). The counter clears on entry to BUSY and increments every BUSY cycle.
- stall_mult = (mfhi_d | mflo_d) & (busy | start_mult), or mult_e & busy (structural hazard; the second multiply is held in E), or the IDLE not-ready case above.
  - The stall is deasserted in the cycle after mult_done, so mfhi/mflo read the updated HI/LO.
- HI/LO update, registered on the rising edge:
  - On mult_done in BUSY: hi <= product[2W-1:W], lo <= product[W-1:0].
  - On mthi_w: hi <= wdata_w. On mtlo_w: lo <= wdata_w.
  - Same-cycle mult_done and mthi/mtlo: the product wins, because the multiply is the younger instruction.
  - mthi_w and mtlo_w together update both registers.
- hi/lo are continuously driven and need no forwarding: the decode-stage read occurs the cycle after the update.
- Timeout: set timeout_err (sticky until reset), return to IDLE, leave hi/lo unchanged, deassert stall_mult.
- Multiplier latency is taken from mult_done, not assumed; any latency from 1 to MAX_CYCLES-1 is legal.

Test Plan:
- Signed multiply: reset, mult_e=1, mult_sign_e=1, srcs -3 and 5, done after 33 cycles -> start_mult is one 1-cycle pulse with mult_sign=1; busy=1 for 33 cycles; hi=0xFFFFFFFF, lo=0xFFFFFFF1 the cycle after done.
- mflo during multiply: mflo_d=1 two cycles after start -> stall_mult=1 every cycle until done; stall_mult=0 the cycle after done with lo already updated.
- Back-to-back multiplies: second mult_e while busy -> stall_mult=1, no second start_mult; second start fires in the first IDLE cycle with mult_ready=1.
- mthi/done collision: mthi_w with wdata_w=0x12345678 in the same cycle as mult_done with product=0xAAAA_0000_0000_0001 -> hi=0xAAAA0000, lo=0x00000001. mtlo alone later with 0x55 -> lo=0x55, hi unchanged.
- Timeout: mult_done never asserted -> after 40 busy cycles, timeout_err=1 (sticky), busy=0, stall_mult=0, hi/lo unchanged.
- Reset mid-multiply: reset pulsed at busy cycle 10, then a stray mult_done -> state IDLE, hi=lo=0, no update from the stray done.
